// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and default frame geometry.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to 1,
// the idle level of the line, so leaving reset never looks like a start edge.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the line twice into the clk domain.
  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control stage. Qualifies the start bit, strobes `shift` with the
// centre-sampled data bit (LSB first), checks the stop bit and pulses frame status.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit, the PARITY state
// and the parity_err output.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_tick,
  input  logic rx,
  output logic shift,
  output logic rx_bit,
  output logic rx_done,
  output logic frame_err,
`ifdef UART_RX_PARITY_EN
  output logic parity_err,
`endif
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Tick counts at which the start bit and every later bit are sampled.
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic            rx_s;
  rx_state_e       state;
  logic [TW-1:0]   tcnt;
  logic [BW-1:0]   bcnt;
  logic            armed;

`ifdef UART_RX_PARITY_EN
  logic            par_acc;
  logic            par_err_q;
`else
  // Odd/even selection only matters when the parity bit is present.
  logic            parity_odd_unused;
  assign parity_odd_unused = (PARITY_ODD != 0);
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM with registered outputs; every decision is taken on a baud_tick cycle.
  // NOTE: reset is asynchronous, so outputs drop to 0 as soon as reset rises, mid-frame included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      armed      <= 1'b0;
      shift      <= 1'b0;
      rx_bit     <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc    <= 1'b0;
      par_err_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low every clk, so each lasts one clk whatever the tick spacing.
      shift      <= 1'b0;
      rx_bit     <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (baud_tick) begin
        unique case (state)
          IDLE: begin
            // A high line re-arms detection; after a break we wait for it here.
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= START;
              tcnt  <= '0;
              busy  <= 1'b1;
            end
          end

          START: begin
            if (tcnt == T_MID) begin
              if (!rx_s) begin
                state   <= DATA;
                tcnt    <= '0;
                bcnt    <= '0;
`ifdef UART_RX_PARITY_EN
                par_acc <= 1'b0;
`endif
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end

          DATA: begin
            if (tcnt == T_END) begin
              rx_bit  <= rx_s;
              shift   <= 1'b1;
              bcnt    <= bcnt + 1'b1;
              tcnt    <= '0;
`ifdef UART_RX_PARITY_EN
              par_acc <= par_acc ^ rx_s;
              if (bcnt == B_LAST) state <= PARITY;
`else
              if (bcnt == B_LAST) state <= STOP;
`endif
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tcnt == T_END) begin
              par_err_q <= (rx_s != (par_acc ^ (PARITY_ODD != 0)));
              tcnt      <= '0;
              state     <= STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
`endif

          STOP: begin
            if (tcnt == T_END) begin
              rx_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_err_q;
`endif
              if (!rx_s) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
              tcnt  <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table-driven frames, hand-written corner
// sequences and randomized frames checked against a byte-level reference.
module tb_uart_rx_ctrl;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 0;
  localparam int TICK_DIV   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud_tick = 1'b0;
  logic rx = 1'b1;
  logic shift, rx_bit, rx_done, frame_err, busy;
  logic parity_err;

  uart_rx_ctrl #(
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .shift      (shift),
    .rx_bit     (rx_bit),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  // Baud tick: one clk in every TICK_DIV, driven just after the rising edge.
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      baud_tick = (n % TICK_DIV == 0);
    end
  end

  // ---------------- monitor: downstream shift register + event log ----------------
  int shift_cnt, done_cnt, width_err, orphan_err;
  logic [DATA_BITS-1:0] sreg;
  logic [DATA_BITS-1:0] frames_q[$];
  bit ferr_q[$];
  bit perr_q[$];
  bit bits_q[$];
  logic prev_shift = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (shift === 1'b1) begin
      shift_cnt++;
      bits_q.push_back(rx_bit);
      sreg = {rx_bit, sreg[DATA_BITS-1:1]};
    end
    if (rx_done === 1'b1) begin
      done_cnt++;
      frames_q.push_back(sreg);
      ferr_q.push_back(frame_err);
      perr_q.push_back(parity_err);
    end
    if ((frame_err === 1'b1 || parity_err === 1'b1) && rx_done !== 1'b1) orphan_err++;
    if ((shift === 1'b1 && prev_shift === 1'b1) || (rx_done === 1'b1 && prev_done === 1'b1))
      width_err++;
    prev_shift = shift;
    prev_done  = rx_done;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    shift_cnt = 0;
    done_cnt  = 0;
    sreg      = '0;
    frames_q.delete();
    ferr_q.delete();
    perr_q.delete();
    bits_q.delete();
  endtask

  function automatic logic [31:0] frame_at(input int i);
    if (i < frames_q.size()) return 32'(frames_q[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] ferr_at(input int i);
    if (i < ferr_q.size()) return 32'(ferr_q[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] perr_at(input int i);
    if (i < perr_q.size()) return 32'(perr_q[i]);
    return 'x;
  endfunction

  // ---------------- line driving ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
    #2;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // Start bit, data LSB first, optional parity (flipped on request), stop bit.
  // The line is left at the stop-bit level.
  task automatic send_frame(input logic [DATA_BITS-1:0] data, input bit stop, input bit pflip);
    rx = 1'b0;
    wait_ticks(OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = data[i];
      wait_ticks(OVERSAMPLE);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ (PARITY_ODD != 0) ^ pflip;
    wait_ticks(OVERSAMPLE);
`else
    if (pflip) $display("note: parity flip ignored without parity bit");
`endif
    rx = stop;
    wait_ticks(OVERSAMPLE);
  endtask

  // One frame as seen downstream: byte, shift count, one rx_done, status flags.
  task automatic check_frame(input string name, input logic [DATA_BITS-1:0] data,
                             input bit exp_ferr, input bit exp_perr);
    check({name, "_shifts"}, shift_cnt, DATA_BITS);
    check({name, "_done"}, done_cnt, 1);
    check({name, "_data"}, frame_at(0), 32'(data));
    check({name, "_ferr"}, ferr_at(0), 32'(exp_ferr));
`ifdef UART_RX_PARITY_EN
    check({name, "_perr"}, perr_at(0), 32'(exp_perr));
`else
    if (exp_perr) $display("note: parity expectation ignored without parity bit");
`endif
  endtask

  typedef struct {
    logic [DATA_BITS-1:0] data;
    bit                   stop;
    bit                   pflip;
    bit                   exp_ferr;
    bit                   exp_perr;
  } vec_t;

  vec_t tbl[6];
  bit   exp_seq[8];

  initial begin
    clear_mon();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_shift", shift, 0);
    check("rst_rx_bit", rx_bit, 0);
    check("rst_done", rx_done, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", parity_err, 0);
`endif
    reset = 1'b0;
    idle(4);

    // 0xA5: bit order on rx_bit, LSB first.
    exp_seq = '{1, 0, 1, 0, 0, 1, 0, 1};
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(4);
    check_frame("a5", 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      check($sformatf("a5_bit%0d", i), (i < bits_q.size()) ? 32'(bits_q[i]) : 'x, 32'(exp_seq[i]));

    // Table-driven frames.
    tbl[0] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) begin
      clear_mon();
      send_frame(tbl[t].data, tbl[t].stop, tbl[t].pflip);
      idle(4);
      check_frame($sformatf("tbl%0d", t), tbl[t].data, tbl[t].exp_ferr, tbl[t].exp_perr);
    end

    // Glitch: low for 3 ticks, then high -> back to IDLE with no outputs.
    clear_mon();
    rx = 1'b0;
    wait_ticks(3);
    check("glitch_busy_hi", busy, 1);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch_busy_lo", busy, 0);
    check("glitch_shifts", shift_cnt, 0);
    check("glitch_done", done_cnt, 0);

    // Framing error followed by a break held low for 40 ticks.
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    wait_ticks(40);
    check_frame("brk", 8'h3C, 1'b1, 1'b0);
    check("brk_busy", busy, 0);
    idle(3);
    clear_mon();
    send_frame(8'h55, 1'b1, 1'b0);
    idle(4);
    check_frame("after_brk", 8'h55, 1'b0, 1'b0);

    // Reset after the 4th shift of a frame.
    clear_mon();
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 3000; k++) begin
          @(negedge clk);
          #1;
          if (shift_cnt == 4 && shift === 1'b1) begin
            hit = 1'b1;
            break;
          end
        end
        check("rst_mid_reached", 32'(hit), 1);
        reset = 1'b1;
        #1;
        check("rst_mid_shift", shift, 0);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    idle(4);
    check("rst_mid_done", done_cnt, 0);
    check("rst_mid_shifts", shift_cnt, 4);
    clear_mon();
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(4);
    check_frame("after_rst", 8'hFF, 1'b0, 1'b0);

    // Back-to-back frames with no idle gap.
    clear_mon();
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    idle(4);
    check("b2b_shifts", shift_cnt, 2 * DATA_BITS);
    check("b2b_done", done_cnt, 2);
    check("b2b_data0", frame_at(0), 32'h12);
    check("b2b_data1", frame_at(1), 32'h34);
    check("b2b_ferr0", ferr_at(0), 0);
    check("b2b_ferr1", ferr_at(1), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1.
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    check_frame("par_ok", 8'h07, 1'b0, 1'b0);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check_frame("par_bad", 8'h07, 1'b0, 1'b1);
`endif

    // Randomized frames against the byte-level reference.
    for (int r = 0; r < 12; r++) begin
      logic [DATA_BITS-1:0] d;
      bit stop, pflip;
      d     = DATA_BITS'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      pflip = 1'($urandom_range(0, 1));
`else
      pflip = 1'b0;
`endif
      clear_mon();
      send_frame(d, stop, pflip);
      idle($urandom_range(2, 5));
      check_frame($sformatf("rnd%0d", r), d, !stop, pflip);
    end

    check("pulse_width", width_err, 0);
    check("orphan_err", orphan_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive control stage. It oversamples the serial line against an external baud tick, qualifies the start bit, and emits one `shift` strobe with the sampled bit at the centre of each data bit. It then checks the stop bit (and optionally parity) and pulses frame-complete status. It sits directly upstream of the receive serial-to-parallel register: `shift`/`rx_bit` drive that register's `shift`/`rx_datain`, and `rx_done` marks when its parallel output is a complete byte.

## Interface
- `OVERSAMPLE`, 16: baud ticks per bit period; even, ≥4.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only with `UART_RX_PARITY_EN`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `baud_tick` in 1: single-cycle enable at `OVERSAMPLE` × baud rate.
- `rx` in 1: asynchronous serial line, idle high.
- `shift` out 1: one-cycle strobe, one per data bit.
- `rx_bit` out 1: sampled data bit; valid while `shift`=1.
- `rx_done` out 1: one-cycle pulse at the end of every frame (good or bad).
- `frame_err` out 1: one-cycle pulse, coincident with `rx_done`, when the stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse, coincident with `rx_done`, on parity mismatch. Present only with `UART_RX_PARITY_EN`.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to produce `rx_s`. `rx_s` resets to 1.
- Internal counters:
  - tick counter `tcnt`, width clog2(`OVERSAMPLE`).
  - bit counter `bcnt`, width clog2(`DATA_BITS`+1).
- `tcnt` advances only on `baud_tick`. All sampling decisions occur on `baud_tick` cycles.
- States and transitions:
  - IDLE: `armed` sets when `rx_s`=1 on a tick. If `armed` and `rx_s`=0 on a tick, go to START with `tcnt`=0.
  - START: on the tick where `tcnt`=`OVERSAMPLE`/2−1:
    - `rx_s`=0: go to DATA with `tcnt`=0 and `bcnt`=0.
    - otherwise, glitch: return to IDLE with no outputs.
  - DATA: on the tick where `tcnt`=`OVERSAMPLE`−1:
    - register `rx_bit`=`rx_s`, pulse `shift`, increment `bcnt`, set `tcnt`=0.
    - after bit `DATA_BITS`−1, go to PARITY if the macro is defined, else STOP.
  - PARITY: on the tick where `tcnt`=`OVERSAMPLE`−1, compare `rx_s` with the expected parity and latch the error. Go to STOP.
  - STOP: on the tick where `tcnt`=`OVERSAMPLE`−1, pulse `rx_done`. If `rx_s`=0, also pulse `frame_err` and clear `armed`. Go to IDLE.
- Bits are LSB first. After `DATA_BITS` shifts, the downstream register holds the first received bit at bit 0.
- Expected parity = XOR of the data bits (even), inverted when `PARITY_ODD`=1.
- A line held low after a framing error (break) produces no new frame until `rx_s` is seen high on a tick.

## Timing
- Reset values: `shift`, `rx_bit`, `rx_done`, `frame_err`, `parity_err` and `busy` are 0. State = IDLE, counters = 0, `armed` = 0, `rx_s` = 1.
- `rx` to `rx_s` latency: 2 clk cycles.
- All outputs are registered. `shift`/`rx_bit`, `rx_done` and the error pulses rise 1 clk after the sampling tick edge and last exactly 1 clk, independent of the tick spacing.
- Samples fall at bit centres: start bit at tick `OVERSAMPLE`/2 after the falling edge is detected; each subsequent bit `OVERSAMPLE` ticks later.
- Reset asserted mid-frame: all outputs return to 0 immediately. No `rx_done` is issued for the partial frame.
- `baud_tick` held low: the FSM freezes and the outputs hold at 0.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state, `parity_err` port and the parity accumulator are present.
  - Frame = start + `DATA_BITS` + parity + stop.
- Not defined:
  - No PARITY state and no `parity_err` port.
  - DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP).
  - default `OVERSAMPLE`/`DATA_BITS` constants.
- Sub-module `uart_rx_sync`: 2-flop synchronizer, reset to 1.

## Test plan
- Frame 0xA5, `OVERSAMPLE`=16, tick every 4 clk:
  - 8 `shift` pulses with `rx_bit` = 1,0,1,0,0,1,0,1.
  - then `rx_done`=1 with `frame_err`=0; downstream register = 0xA5.
- `rx` low for 3 ticks then high: return to IDLE; zero `shift` pulses, no `rx_done`.
- Frame 0x3C with stop bit low, line held low 40 ticks:
  - `rx_done` and `frame_err` pulse together.
  - no new START until `rx` goes high; then frame 0x55 is received cleanly.
- Reset asserted after the 4th `shift`: outputs go to 0 in the same cycle; a following 0xFF frame yields exactly 8 shifts and a clean `rx_done`.
- With `UART_RX_PARITY_EN`, `PARITY_ODD`=0:
  - 0x07 with parity bit 1: `parity_err`=0.
  - same frame with parity bit 0: `parity_err`=1, coincident with `rx_done`.
- Back-to-back frames 0x12, 0x34 with no idle gap: 16 shifts, two `rx_done` pulses, no errors.
